// File: rtl/counter_mod_updown_if.sv
// -----------------------------------------------------------------------------
// counter_mod_updown_if
//   Control/status bundle for one modulo-N up/down counter stage.
//
//   Signals
//     en        count enable; gates the prescaler and stepping
//     up_dn     direction, 1 = up, 0 = down
//     clr       synchronous clear, active-high
//     load      synchronous parallel load, active-high
//     load_val  value for load (saturated to MOD-1 by the counter)
//     q         registered count
//     tc        combinational terminal count for the current direction
//     wrap      registered one-cycle pulse, high while q holds a wrapped value
//
//   Modports
//     master  the controlling side (drives controls, observes the count)
//     slave   the counter itself
// -----------------------------------------------------------------------------
interface counter_mod_updown_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             up_dn;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up_dn, clr, load, load_val,
        input  q, tc, wrap
    );

    modport slave (
        input  en, up_dn, clr, load, load_val,
        output q, tc, wrap
    );
endinterface : counter_mod_updown_if

// File: rtl/counter_mod_updown.sv
// -----------------------------------------------------------------------------
// counter_mod_updown
//   Parametrised modulo-N up/down counter with built-in prescaler,
//   synchronous clear, saturating parallel load and a terminal-count/wrap
//   pair for cascading digits (e.g. BCD chains feeding 7-segment decoders).
//
//   The count width must hold the modulus (at least two values), and the
//   prescale factor sets how many enabled cycles make one count step.
//   Clocking is on the rising edge of clk with a synchronous active-low
//   reset on rst; all controls and status travel on the slave modport of
//   counter_mod_updown_if.
//
//   Per-edge priority: rst=0 > clr > load > step > hold.
//   Cascading: qualify the next stage with en_next = en & tc.
// -----------------------------------------------------------------------------
module counter_mod_updown #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MOD      = 10,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    counter_mod_updown_if.slave   bus
);

    // A one-bit prescaler is kept when PRESCALE == 1; its compare value is 0,
    // so it never leaves 0 and synthesis folds it away.
    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] Q_MAX    = WIDTH'(MOD - 1);
    // One extra bit so a modulus of 2**WIDTH is representable for the load compare.
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD);

    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    pre_q,   pre_d;
    logic             wrap_q,  wrap_d;

    logic [WIDTH-1:0] load_sat;
    logic             pre_last;

    assign load_sat = ({1'b0, bus.load_val} < MOD_EXT) ? bus.load_val : Q_MAX;
    assign pre_last = (pre_q == PRE_LAST);

    always_comb begin
        // NOTE: every signal driven here gets a default first so that no path
        // leaves it unassigned, which would otherwise infer a latch.
        count_d = count_q;
        pre_d   = pre_q;
        wrap_d  = 1'b0;

        if (bus.clr) begin
            count_d = '0;
            pre_d   = '0;
        end else if (bus.load) begin
            count_d = load_sat;
            pre_d   = '0;
        end else if (bus.en) begin
            if (pre_last) begin
                pre_d = '0;
                if (bus.up_dn) begin
                    if (count_q == Q_MAX) begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q + WIDTH'(1);
                    end
                end else begin
                    if (count_q == '0) begin
                        count_d = Q_MAX;
                        wrap_d  = 1'b1;
                    end else begin
                        count_d = count_q - WIDTH'(1);
                    end
                end
            end else begin
                // Partial progress is held whenever en drops.
                pre_d = pre_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            count_q <= '0;
            pre_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            pre_q   <= pre_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.q    = count_q;
    assign bus.wrap = wrap_q;
    // Not gated by en: a chain uses en & tc to enable the next digit.
    assign bus.tc   = bus.up_dn ? (count_q == Q_MAX) : (count_q == '0);

endmodule : counter_mod_updown

// File: tb/tb_counter_mod_updown.sv
// -----------------------------------------------------------------------------
// tb_counter_mod_updown
//   Drives four counter instances from one directed-then-random sequence:
//     dut_a   MOD=10, PRESCALE=1
//     dut_p   MOD=10, PRESCALE=4   (same controls as dut_a)
//     dut_c0  MOD=10, PRESCALE=1   cascade units digit
//     dut_c1  MOD=10, PRESCALE=1   cascade tens digit, en = en_c & tc0
//   Expected values come from an arithmetic reference model of the counter
//   rules (modulo arithmetic on integers) and of the two-digit cascade
//   (a single 0..99 integer).
// -----------------------------------------------------------------------------
module tb_counter_mod_updown;

    localparam int MOD = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;
    logic       en_c;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int ea_q, ea_pre, ea_wrap;
    int ep_q, ep_pre, ep_wrap;
    int ec_cnt, ec_wrap;
    int wrap1_seen;

    always #5 clk = ~clk;

    counter_mod_updown_if #(.WIDTH(4)) if_a  ();
    counter_mod_updown_if #(.WIDTH(4)) if_p  ();
    counter_mod_updown_if #(.WIDTH(4)) if_c0 ();
    counter_mod_updown_if #(.WIDTH(4)) if_c1 ();

    assign if_a.en = en;       assign if_a.up_dn = up_dn;
    assign if_a.clr = clr;     assign if_a.load = load;
    assign if_a.load_val = load_val;

    assign if_p.en = en;       assign if_p.up_dn = up_dn;
    assign if_p.clr = clr;     assign if_p.load = load;
    assign if_p.load_val = load_val;

    assign if_c0.en = en_c;    assign if_c0.up_dn = 1'b1;
    assign if_c0.clr = 1'b0;   assign if_c0.load = 1'b0;
    assign if_c0.load_val = 4'd0;

    assign if_c1.en = en_c & if_c0.tc;
    assign if_c1.up_dn = 1'b1;
    assign if_c1.clr = 1'b0;   assign if_c1.load = 1'b0;
    assign if_c1.load_val = 4'd0;

    counter_mod_updown #(.WIDTH(4), .MOD(MOD), .PRESCALE(1)) dut_a  (.clk(clk), .rst(rst_n), .bus(if_a));
    counter_mod_updown #(.WIDTH(4), .MOD(MOD), .PRESCALE(4)) dut_p  (.clk(clk), .rst(rst_n), .bus(if_p));
    counter_mod_updown #(.WIDTH(4), .MOD(MOD), .PRESCALE(1)) dut_c0 (.clk(clk), .rst(rst_n), .bus(if_c0));
    counter_mod_updown #(.WIDTH(4), .MOD(MOD), .PRESCALE(1)) dut_c1 (.clk(clk), .rst(rst_n), .bus(if_c1));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counter rules applied to the inputs present before the edge.
    task automatic model(input int ps, inout int q, inout int pre, output int w);
        w = 0;
        if (!rst_n) begin
            q = 0; pre = 0;
        end else if (clr) begin
            q = 0; pre = 0;
        end else if (load) begin
            q = (int'(load_val) < MOD) ? int'(load_val) : MOD - 1;
            pre = 0;
        end else if (en) begin
            if (pre == ps - 1) begin
                pre = 0;
                if (up_dn) begin
                    w = (q == MOD - 1) ? 1 : 0;
                    q = (q + 1) % MOD;
                end else begin
                    w = (q == 0) ? 1 : 0;
                    q = (q + MOD - 1) % MOD;
                end
            end else begin
                pre++;
            end
        end
    endtask

    // Two-digit cascade seen as one decimal number 0..99.
    task automatic cascade_model();
        ec_wrap = 0;
        if (!rst_n) begin
            ec_cnt = 0;
        end else if (en_c) begin
            ec_wrap = (ec_cnt == 99) ? 1 : 0;
            ec_cnt  = (ec_cnt + 1) % 100;
        end
    endtask

    function automatic int exp_tc(input int q);
        return up_dn ? ((q == MOD - 1) ? 1 : 0) : ((q == 0) ? 1 : 0);
    endfunction

    // Advance one clock: update the model, let the edge happen, compare #1 later.
    task automatic cycle();
        model(1, ea_q, ea_pre, ea_wrap);
        model(4, ep_q, ep_pre, ep_wrap);
        cascade_model();
        @(posedge clk);
        #1;
        check("a_q",    32'(if_a.q),    32'(ea_q));
        check("a_wrap", 32'(if_a.wrap), 32'(ea_wrap));
        check("a_tc",   32'(if_a.tc),   32'(exp_tc(ea_q)));
        check("p_q",    32'(if_p.q),    32'(ep_q));
        check("p_wrap", 32'(if_p.wrap), 32'(ep_wrap));
        check("p_tc",   32'(if_p.tc),   32'(exp_tc(ep_q)));
        check("c_val",  32'(int'(if_c1.q) * 10 + int'(if_c0.q)), 32'(ec_cnt));
        check("c_wrap1", 32'(if_c1.wrap), 32'(ec_wrap));
        if (if_c1.wrap === 1'b1) wrap1_seen++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        ea_q = 0; ea_pre = 0; ea_wrap = 0;
        ep_q = 0; ep_pre = 0; ep_wrap = 0;
        ec_cnt = 0; ec_wrap = 0; wrap1_seen = 0;
        rst_n = 1'b0; en = 1'b1; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = 4'd0; en_c = 1'b0;

        // Reset with en high, then hold with en low
        cycles(2);
        check("reset_q", 32'(if_a.q), 32'd0);
        rst_n = 1'b1; en = 1'b0;
        cycles(5);

        // Up count through a full wrap
        en = 1'b1; up_dn = 1'b1;
        cycles(10);
        check("up_wrap_q", 32'(if_a.q), 32'd0);

        // Down count from 2 across the zero boundary
        load = 1'b1; load_val = 4'd2;
        cycles(1);
        load = 1'b0; up_dn = 1'b0;
        cycles(4);
        check("down_q", 32'(if_a.q), 32'd8);

        // Prescale: fresh start, 12 enabled cycles -> 3 steps
        rst_n = 1'b0; cycles(1);
        rst_n = 1'b1; up_dn = 1'b1; en = 1'b1;
        cycles(12);
        check("p_12cyc", 32'(if_p.q), 32'd3);

        // Prescale with en dropped for 3 cycles after cycle 2 -> step at cycle 7
        rst_n = 1'b0; cycles(1);
        rst_n = 1'b1; en = 1'b1;
        cycles(2);
        en = 1'b0; cycles(3);
        en = 1'b1; cycles(1);
        check("p_before_step", 32'(if_p.q), 32'd0);
        cycles(1);
        check("p_step7", 32'(if_p.q), 32'd1);

        // Load, saturating load, clear over load
        load = 1'b1; load_val = 4'd7; cycles(1);
        check("load7", 32'(if_a.q), 32'd7);
        load_val = 4'd12; cycles(1);
        check("load_sat", 32'(if_a.q), 32'd9);
        clr = 1'b1; load_val = 4'd5; cycles(1);
        check("clr_wins", 32'(if_a.q), 32'd0);
        clr = 1'b0; load = 1'b0;

        // Load on the prescale step edge restarts the prescaler
        cycles(3);
        load = 1'b1; load_val = 4'd4; cycles(1);
        load = 1'b0;
        check("p_load_step", 32'(if_p.q), 32'd4);
        cycles(3);
        check("p_load_hold", 32'(if_p.q), 32'd4);
        cycles(1);
        check("p_load_next", 32'(if_p.q), 32'd5);

        // Cascade: 100 enabled cycles from reset -> 00..99 then 00
        en = 1'b0;
        rst_n = 1'b0; cycles(1);
        rst_n = 1'b1; en_c = 1'b1; wrap1_seen = 0;
        cycles(100);
        check("casc_end", 32'(int'(if_c1.q) * 10 + int'(if_c0.q)), 32'd0);
        check("casc_wrap1_once", 32'(wrap1_seen), 32'd1);
        cycles(5);
        en_c = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            rst_n    = ($urandom_range(0, 49) != 0);
            en       = ($urandom_range(0, 3) != 0);
            up_dn    = $urandom_range(0, 1) != 0;
            clr      = ($urandom_range(0, 29) == 0);
            load     = ($urandom_range(0, 19) == 0);
            load_val = 4'($urandom_range(0, 15));
            en_c     = ($urandom_range(0, 1) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_counter_mod_updown
